// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide with a fixed XLEN+2 cycle latency from the cycle start is first seen.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      fn3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        fn3_q, fn3_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic [XLEN-1:0]   mag_a_q, mag_a_d;
  logic [XLEN-1:0]   mag_b_q, mag_b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed;
  logic [XLEN-1:0]   in_mag_a, in_mag_b;
  logic [XLEN:0]     mul_sum, div_trial, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // Datapath: the accumulator holds the product during multiply and the
  // remainder:quotient pair during divide.
  always_comb begin
    a_signed  = (fn3 == 3'b001) || (fn3 == 3'b010) || (fn3 == 3'b100) || (fn3 == 3'b110);
    b_signed  = (fn3 == 3'b001) || (fn3 == 3'b100) || (fn3 == 3'b110);
    in_mag_a  = (a_signed && op_a[XLEN-1]) ? -op_a : op_a;
    in_mag_b  = (b_signed && op_b[XLEN-1]) ? -op_b : op_b;

    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mag_a_q & {XLEN{acc_q[0]}}};
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};

    div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_trial - {1'b0, mag_b_q};
    div_next  = div_diff[XLEN] ? {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

    // A zero divisor leaves the quotient all ones and must not be negated.
    prod_fix  = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo_fix   = ((neg_a_q ^ neg_b_q) && (mag_b_q != '0)) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix   = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    fn3_d    = fn3_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          busy_d  = 1'b1;
          fn3_d   = fn3;
          neg_a_d = a_signed && op_a[XLEN-1];
          neg_b_d = b_signed && op_b[XLEN-1];
          mag_a_d = in_mag_a;
          mag_b_d = in_mag_b;
          acc_d   = fn3[2] ? {{XLEN{1'b0}}, in_mag_a} : {{XLEN{1'b0}}, in_mag_b};
          cnt_d   = CW'(XLEN - 1);
        end
      end
      CALC: begin
        acc_d = fn3_q[2] ? div_next : mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        case (fn3_q)
          3'b000:                   result_d = acc_q[XLEN-1:0];
          3'b001, 3'b010, 3'b011:   result_d = prod_fix[2*XLEN-1:XLEN];
          3'b100, 3'b101:           result_d = quo_fix;
          default:                  result_d = rem_fix;
        endcase
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      fn3_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      fn3_q    <= fn3_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign stall  = start & ~done_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed M-ops, latency, stall and reset.
module tb_muldiv_sequencer;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [2:0]      fn3 = 3'b000;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            busy, done, stall;
  logic [XLEN-1:0] result;

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [XLEN-1:0] res;
    int              cyc;
    string           name;
  } exp_t;

  exp_t exp_q[$];

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .fn3    (fn3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .stall  (stall),
    .result (result)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_done: got done=1 result=%h, expected no done (cycle %0d)", result, cyc);
      end else begin
        e = exp_q.pop_front();
        checkOutput({e.name, " result"}, result, e.res);
        checkOutput({e.name, " done_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Issues one op (called just after a rising edge), holds start until done,
  // optionally scrambles the inputs mid-CALC, and returns just after the next edge.
  task automatic applyStimulus(input string name, input logic [2:0] f,
                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input logic [XLEN-1:0] exp_res, input int perturb_at);
    exp_t e;
    bit   seen;
    fn3   = f;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    e.res  = exp_res;
    e.cyc  = cyc + XLEN + 2;
    e.name = name;
    exp_q.push_back(e);
    seen = 1'b0;
    for (int k = 0; k < XLEN + 8 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        checkOutput({name, " stall_at_done"}, 32'(stall), 32'd0);
      end else begin
        checkOutput({name, " stall_while_pending"}, 32'(stall), 32'd1);
      end
      if (k == perturb_at) begin
        op_a = 32'hDEADBEEF;
        op_b = 32'h00000003;
        fn3  = 3'b000;
      end
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s timeout: got no done, expected done within %0d cycles", name, XLEN + 8);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus("MUL_6x7", 3'b000, 32'd6, 32'd7, 32'h0000002A, -1);
    start = 1'b0;
    #1;
    checkOutput("idle stall_no_start", 32'(stall), 32'd0);
    @(posedge clk);
    #1;

    // Abort a multiply partway through CALC; no done may follow.
    fn3   = 3'b000;
    op_a  = 32'd6;
    op_b  = 32'd7;
    start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("midop busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort result", result, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("abort result_later", result, 32'd0);

    applyStimulus("MUL_neg3x5",   3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, -1);
    applyStimulus("MULH_m1xm1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, -1);
    applyStimulus("MULHSU_m1x2",  3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, -1);
    applyStimulus("MULHU_max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, -1);
    applyStimulus("DIV_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, -1);
    applyStimulus("REM_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, -1);
    applyStimulus("DIV_overflow", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, -1);
    applyStimulus("REM_overflow", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, -1);
    applyStimulus("DIVU_5_0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, -1);
    applyStimulus("REMU_5_0",     3'b111, 32'd5,        32'd0,        32'h00000005, -1);
    applyStimulus("DIV_m5_0",     3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, -1);
    applyStimulus("REM_m5_0",     3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, -1);
    applyStimulus("DIVU_100_7",   3'b101, 32'd100,      32'd7,        32'h0000000E, 10);
    start = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
